trng_collector: RTL and testbench
=================================

Name: trng_collector

Overview:
- Consumer end of the ring-mux entropy source on the Basys3 board.
- Drives the 3-bit mux-tree select and samples the source's raw output bit.
- Removes bias with a von Neumann extractor and packs debiased bits into WORD_W-bit words.
- Presents each word on a valid/ready handshake to downstream logic (UART dumper, LED display).

Parameters:
WORD_W, 8, width of each output random word (>=2)
SAMPLE_DIV, 4, clocks between raw-bit samples (>=2)
RCT_LIMIT, 32, repetition-count threshold for the health test (used only with TRNG_HEALTH_EN)

Ports:
clk  input  1  system clock (100 MHz)
rst_n  input  1  reset; one clock, asynchronous, active-low
en  input  1  sampling enable
raw_bit  input  1  asynchronous raw bit from the mux-tree source
sel  output  3  select vector driven to the mux tree
word  output  WORD_W  random word, valid while word_valid=1
word_valid  output  1  output word available
word_ready  input  1  downstream accepts word
health_fail  output  1  sticky health-test failure flag

Behaviour:
Reset (rst_n low, asynchronous):
- sel=0, word=0, word_valid=0, health_fail=0.
- Divider, pair FSM, shift register, bit count and RCT counter all cleared.
- Mid-word reset discards the partial word and any pending output.

Input sampling:
- raw_bit passes through a 2-flop synchronizer.
- The "sample" is the synchronizer output on a strobe cycle.
- Divider counts 0..SAMPLE_DIV-1 while en=1.
- Strobe fires when divider==SAMPLE_DIV-1 and en=1; divider then wraps to 0.
- On each strobe, sel increments mod 8 (7->0).

Pair FSM (states FIRST, SECOND):
- FIRST, on strobe: store sample as b0; go to SECOND.
- SECOND, on strobe with b0!=sample: emit debiased bit = b0 (pair 10->1, 01->0); go to FIRST.
- SECOND, on strobe with b0==sample: emit nothing; go to FIRST.
- en=0: divider held at 0, FSM forced to FIRST (held b0 discarded), sel held, partial word and count kept.

Assembly:
- On each emitted bit: shift_reg <= {shift_reg[WORD_W-2:0], bit}; count increments.
- When count reaches WORD_W the shift register is full.
- If the output slot is empty, or being consumed this cycle (word_valid & word_ready), word loads from the shift register on the next edge and count clears.
- Latency: word_valid rises 1 clock after the strobe that completes the word.
- Output slot occupied and not consumed: shift register holds its full word; further debiased bits are dropped until the slot frees.
- Slot freed: full shift register loads on the cycle after the transfer.

Handshake:
- Transfer occurs on word_valid & word_ready.
- word is stable while word_valid=1 and not yet transferred.
- Simultaneous transfer and new-word completion: new word loads and word_valid stays 1.
- word_ready with word_valid=0 has no effect.

Optional Feature:
TRNG_HEALTH_EN:
- Defined: repetition-count test on strobe samples (before debiasing).
  - RCT counter resets to 1 when a sample differs from the previous one; otherwise increments, saturating.
  - Counter reaching RCT_LIMIT sets health_fail=1, sticky until rst_n.
  - While health_fail=1, no new word loads into the output slot; an already pending word may still transfer.
  - sel and the pair FSM keep running.
- Undefined: RCT logic absent; health_fail tied 0.

Decomposition:
- Package trng_pkg: default WORD_W, SAMPLE_DIV and RCT_LIMIT constants; pair-FSM state enum (FIRST, SECOND); SEL_W=3.
- One sub-module, trng_vn_debias: pair FSM only. Inputs clk, rst_n, strobe, sample, clear; outputs bit_valid, bit.

Test Plan:
- Async reset: assert rst_n low mid-word with word_valid=1 -> word_valid=0, word=0x00, sel=0 immediately without a clock edge; first word after release contains only post-reset bits.
- Default parameters, samples in pairs 10 x8 -> word=0xFF; pairs 01 x8 -> word=0x00; alternating 10,01 x4 -> word=0xAA; word_valid rises 1 clock after the 16th strobe.
- Only equal pairs (00/11) for 64 strobes -> word_valid stays 0, count stays 0.
- word_ready=0 while two words (0xAA then 0x55) complete -> word holds 0xAA, later bits dropped; raise word_ready 1 cycle -> transfer 0xAA, word=0x55 and word_valid=1 on the next cycle.
- en=1 for 32 clocks -> sel steps 0..7 every 4 clocks and wraps to 0; drop en -> sel and divider freeze.
- With TRNG_HEALTH_EN, raw_bit stuck at 1 -> health_fail=1 on the 32nd strobe, stays 1 after raw_bit toggles, no further word_valid until reset.

Source files
------------

// File: rtl/trng_pkg.sv
// ----------------------------------------------------------------------------
// trng_pkg
// Shared constants and types for the ring-mux TRNG collector.
//   WORD_W_DEF     : default output word width
//   SAMPLE_DIV_DEF : default clocks between raw-bit samples
//   RCT_LIMIT_DEF  : default repetition-count threshold (health test)
//   SEL_W          : width of the mux-tree select vector
//   pair_state_e   : von Neumann pair FSM states
// ----------------------------------------------------------------------------
package trng_pkg;

    localparam int WORD_W_DEF     = 8;
    localparam int SAMPLE_DIV_DEF = 4;
    localparam int RCT_LIMIT_DEF  = 32;
    localparam int SEL_W          = 3;

    typedef enum logic {
        FIRST  = 1'b0,
        SECOND = 1'b1
    } pair_state_e;

endpackage

// File: rtl/trng_vn_debias.sv
// ----------------------------------------------------------------------------
// trng_vn_debias
// Von Neumann pair FSM. Consumes one sample per strobe, groups samples into
// non-overlapping pairs and emits the first bit of every unequal pair.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   FIRST  | waiting for the first sample of a pair
//   SECOND | first sample held in b0, waiting for the second sample
//
// Ports:
//   clk          : system clock
//   rst_n        : asynchronous active-low reset
//   strobe_i     : sample strobe (one cycle)
//   sample_i     : synchronised raw sample, valid when strobe_i=1
//   clear_i      : forces FIRST and discards a held first sample
//   bit_valid_o  : debiased bit available this cycle
//   bit_o        : debiased bit (pair 10 -> 1, 01 -> 0)
// ----------------------------------------------------------------------------
module trng_vn_debias
    import trng_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic strobe_i,
    input  logic sample_i,
    input  logic clear_i,
    output logic bit_valid_o,
    output logic bit_o
);

    pair_state_e state_q, state_d;
    logic        b0_q, b0_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FIRST;
            b0_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            b0_q    <= b0_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        b0_d        = b0_q;
        bit_valid_o = 1'b0;
        if (clear_i) begin
            state_d = FIRST;
        end else if (strobe_i) begin
            case (state_q)
                FIRST: begin
                    b0_d    = sample_i;
                    state_d = SECOND;
                end
                SECOND: begin
                    bit_valid_o = (b0_q != sample_i);
                    state_d     = FIRST;
                end
                default: state_d = FIRST;
            endcase
        end
    end

    // The emitted bit of an unequal pair is always the first sample.
    assign bit_o = b0_q;

endmodule

// File: rtl/trng_collector.sv
// ----------------------------------------------------------------------------
// trng_collector
// Consumer end of the ring-mux entropy source. Steps the mux-tree select,
// samples the raw bit through a 2-flop synchroniser, debiases with a von
// Neumann extractor and packs the result into WORD_W-bit words presented on
// a valid/ready handshake.
//
// Build option:
//   TRNG_HEALTH_EN : adds a repetition-count test on the strobe samples; a run
//                    of RCT_LIMIT equal samples sets a sticky health_fail that
//                    blocks new words. Without it health_fail is tied low.
//
// Ports:
//   clk         : system clock (100 MHz)
//   rst_n       : asynchronous active-low reset
//   en          : sampling enable
//   raw_bit     : asynchronous raw bit from the mux tree
//   sel         : mux-tree select, advances once per sample strobe
//   word        : random word, valid while word_valid=1
//   word_valid  : output word available
//   word_ready  : downstream accepts word
//   health_fail : sticky health-test failure flag
// ----------------------------------------------------------------------------
module trng_collector
    import trng_pkg::*;
#(
    parameter int WORD_W     = WORD_W_DEF,
    parameter int SAMPLE_DIV = SAMPLE_DIV_DEF,
    parameter int RCT_LIMIT  = RCT_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              raw_bit,
    output logic [SEL_W-1:0]  sel,
    output logic [WORD_W-1:0] word,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              health_fail
);

    localparam int DIV_W = $clog2(SAMPLE_DIV);
    localparam int CNT_W = $clog2(WORD_W + 1);

    logic              meta_q, sync_q;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              valid_q, valid_d;

    logic strobe;
    logic deb_valid, deb_bit;
    logic full, xfer, load, hold_out;

    // ------------------------------------------------------------------
    // Raw-bit synchroniser
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= raw_bit;
            sync_q <= meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Sample divider and select stepping
    // ------------------------------------------------------------------
    assign strobe = en && (div_q == DIV_W'(SAMPLE_DIV - 1));

    always_comb begin
        div_d = div_q;
        sel_d = sel_q;
        if (!en || strobe) begin
            div_d = '0;
        end else begin
            div_d = div_q + DIV_W'(1);
        end
        if (strobe) begin
            sel_d = sel_q + SEL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            sel_q <= '0;
        end else begin
            div_q <= div_d;
            sel_q <= sel_d;
        end
    end

    // ------------------------------------------------------------------
    // Von Neumann extractor
    // ------------------------------------------------------------------
    trng_vn_debias u_debias (
        .clk         (clk),
        .rst_n       (rst_n),
        .strobe_i    (strobe),
        .sample_i    (sync_q),
        .clear_i     (!en),
        .bit_valid_o (deb_valid),
        .bit_o       (deb_bit)
    );

    // ------------------------------------------------------------------
    // Optional repetition-count health test
    // ------------------------------------------------------------------
`ifdef TRNG_HEALTH_EN
    localparam int RCT_W = $clog2(RCT_LIMIT + 1);

    logic             prev_q, prev_d;
    logic [RCT_W-1:0] rct_q, rct_d;
    logic             fail_q, fail_d;

    always_comb begin
        prev_d = prev_q;
        rct_d  = rct_q;
        fail_d = fail_q;
        if (strobe) begin
            prev_d = sync_q;
            // A zero count marks "no previous sample yet" after reset.
            if ((rct_q == '0) || (sync_q != prev_q)) begin
                rct_d = RCT_W'(1);
            end else if (rct_q != RCT_W'(RCT_LIMIT)) begin
                rct_d = rct_q + RCT_W'(1);
            end
            if (rct_d == RCT_W'(RCT_LIMIT)) begin
                fail_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
            rct_q  <= '0;
            fail_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
            rct_q  <= rct_d;
            fail_q <= fail_d;
        end
    end

    assign hold_out    = fail_q;
    assign health_fail = fail_q;
`else
    assign hold_out    = 1'b0;
    // Without the health test the flag is constant low; the comparison only
    // keeps RCT_LIMIT referenced so the parameter list stays identical.
    assign health_fail = (RCT_LIMIT < 0);
`endif

    // ------------------------------------------------------------------
    // Word assembly and output slot
    // ------------------------------------------------------------------
    assign full = (cnt_q == CNT_W'(WORD_W));
    assign xfer = valid_q && word_ready;
    // A full word may move into the slot on the same edge the old one leaves.
    assign load = full && (!valid_q || xfer) && !hold_out;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        valid_d = valid_q;
        if (xfer) begin
            valid_d = 1'b0;
        end
        if (load) begin
            word_d  = shift_q;
            valid_d = 1'b1;
            cnt_d   = '0;
        end else if (deb_valid && !full) begin
            // Bits arriving while the shift register is full are dropped.
            shift_d = {shift_q[WORD_W-2:0], deb_bit};
            cnt_d   = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

    assign sel        = sel_q;
    assign word       = word_q;
    assign word_valid = valid_q;

endmodule

// File: tb/tb_trng_collector.sv
// ----------------------------------------------------------------------------
// tb_trng_collector
// Directed bench for trng_collector with default parameters. Expected words
// are queued when their samples are driven; a monitor pops and compares on
// every handshake transfer.
// ----------------------------------------------------------------------------
module tb_trng_collector;

    localparam int DIV = 4;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       raw_bit;
    logic [2:0] sel;
    logic [7:0] word;
    logic       word_valid;
    logic       word_ready;
    logic       health_fail;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];

    trng_collector dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .raw_bit     (raw_bit),
        .sel         (sel),
        .word        (word),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .health_fail (health_fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One sample per divider period; called and returns at a falling edge.
    task automatic send(input logic b);
        en      = 1'b1;
        raw_bit = b;
        repeat (DIV) @(posedge clk);
        @(negedge clk);
    endtask

    // Encode each bit MSB first as a von Neumann pair: 1 -> 10, 0 -> 01.
    task automatic send_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) begin
            send(w[i]);
            send(!w[i]);
        end
    endtask

    // Drop en for one cycle so divider and pair FSM realign.
    task automatic restart();
        en = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        #2;
        check("drain_queue_empty", exp_q.size(), 0);
    endtask

    // Monitor: compare every transferred word with the head of the queue.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && word_valid && word_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_word: got 0x%0h expected none at %0t", word, $time);
                end else begin
                    check("word_out", word, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen_valid;
        rst_n      = 1'b0;
        en         = 1'b0;
        raw_bit    = 1'b0;
        word_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_sel", sel, 0);
        check("reset_word", word, 0);
        check("reset_valid", word_valid, 0);
        check("reset_health", health_fail, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Select stepping: one increment per 4 clocks, wraps after 7.
        en = 1'b1;
        for (int i = 0; i < 38; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i % 4 == 3 || i == 37)
                check("sel_step", sel, ((i + 1) / 4) % 8);
        end
        en = 1'b0;
        repeat (8) @(negedge clk);
        check("sel_frozen", sel, 1);
        en = 1'b1;
        repeat (3) @(negedge clk);
        check("sel_div_held0", sel, 1);
        @(negedge clk);
        check("sel_resume", sel, 2);

        // Basic words with latency check.
        restart();
        exp_q.push_back(8'hFF);
        send_word(8'hFF);
        check("latency_before", word_valid, 0);
        @(negedge clk);
        check("latency_after", word_valid, 1);
        check("latency_word", word, 8'hFF);
        wait_drain();

        restart();
        exp_q.push_back(8'h00);
        send_word(8'h00);
        wait_drain();

        restart();
        exp_q.push_back(8'hAA);
        send_word(8'hAA);
        wait_drain();

        // Equal pairs only: nothing emitted, count stays at zero.
        restart();
        seen_valid = 1'b0;
        for (int i = 0; i < 32; i++) begin
            send(i[0]);
            send(i[0]);
            if (word_valid) seen_valid = 1'b1;
        end
        check("equal_pairs_no_word", seen_valid, 0);
        exp_q.push_back(8'h55);
        send_word(8'h55);
        wait_drain();

        // Backpressure: second word held in shift register, third dropped.
        restart();
        word_ready = 1'b0;
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'h55);
        send_word(8'hAA);
        send_word(8'h55);
        send_word(8'hFF);
        check("bp_hold_word", word, 8'hAA);
        check("bp_hold_valid", word_valid, 1);
        word_ready = 1'b1;
        @(negedge clk);
        word_ready = 1'b0;
        #2;
        check("bp_next_word", word, 8'h55);
        check("bp_next_valid", word_valid, 1);
        @(negedge clk);
        word_ready = 1'b1;
        wait_drain();
        repeat (4) @(negedge clk);
        check("bp_dropped_no_word", word_valid, 0);

        // Asynchronous reset mid-word with a pending output.
        restart();
        word_ready = 1'b0;
        send_word(8'hFF);
        send(1'b1); send(1'b0);
        send(1'b1); send(1'b0);
        check("pre_reset_valid", word_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", word_valid, 0);
        check("async_rst_word", word, 0);
        check("async_rst_sel", sel, 0);
        @(negedge clk);
        rst_n      = 1'b1;
        word_ready = 1'b1;
        restart();
        exp_q.push_back(8'h0F);
        send_word(8'h0F);
        wait_drain();

`ifdef TRNG_HEALTH_EN
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        restart();
        for (int i = 0; i < 31; i++) send(1'b1);
        check("rct_below_limit", health_fail, 0);
        send(1'b1);
        check("rct_at_limit", health_fail, 1);
        seen_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            send(1'b1);
            send(1'b0);
            if (word_valid) seen_valid = 1'b1;
        end
        check("rct_blocks_words", seen_valid, 0);
        check("rct_sticky", health_fail, 1);
`else
        restart();
        for (int i = 0; i < 40; i++) send(1'b1);
        check("no_health_test", health_fail, 0);
`endif

        repeat (4) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
